// File: rtl/traffic_gen_pkg.sv
// Shared definitions for the traffic generator: FSM states, payload modes
// and the maximal-length Fibonacci LFSR tap table.
package traffic_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SETTLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic MODE_INC  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    // Bit k of the mask is polynomial term x^(k+1); feedback is XOR of tapped bits.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            4:       lfsr_taps = 16'h000C;
            5:       lfsr_taps = 16'h0014;
            6:       lfsr_taps = 16'h0030;
            7:       lfsr_taps = 16'h0060;
            8:       lfsr_taps = 16'h00B8;
            9:       lfsr_taps = 16'h0110;
            10:      lfsr_taps = 16'h0240;
            11:      lfsr_taps = 16'h0500;
            12:      lfsr_taps = 16'h0829;
            13:      lfsr_taps = 16'h100D;
            14:      lfsr_taps = 16'h2015;
            15:      lfsr_taps = 16'h6000;
            16:      lfsr_taps = 16'hD008;
            default: lfsr_taps = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/traffic_gen_if.sv
// Control, FIFO-side handshake and status bundle of the traffic generator.
interface traffic_gen_if #(
    parameter int DATA_W = 6,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              mode;
    logic [DATA_W-1:0] seed;
    logic [CNT_W-1:0]  burst_len;
    logic              pause_in;
    logic [NUM_CH-1:0] empty_in;

    logic [DATA_W-1:0] data_out;
    logic              push_out;
    logic [NUM_CH-1:0] pop_out;
    logic              init_out;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  push_cnt;
    logic [CNT_W-1:0]  pop_cnt;

    modport master (
        input  start, mode, seed, burst_len, pause_in, empty_in,
        output data_out, push_out, pop_out, init_out, busy, done, push_cnt, pop_cnt
    );

    modport slave (
        output start, mode, seed, burst_len, pause_in, empty_in,
        input  data_out, push_out, pop_out, init_out, busy, done, push_cnt, pop_cnt
    );
endinterface

// File: rtl/traffic_gen_payload.sv
// Payload source: holds the next word to push, either counting up or
// stepping a Fibonacci LFSR; mode is captured together with the seed.
module traffic_gen_payload
    import traffic_gen_pkg::*;
#(
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic              i_mode,
    input  logic [DATA_W-1:0] i_seed,
    output logic [DATA_W-1:0] o_value
);
    localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

    logic [DATA_W-1:0] r_value;
    logic              r_mode;
    logic              w_fb;

    assign w_fb    = ^(r_value & TAPS);
    assign o_value = r_value;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= '0;
            r_mode  <= MODE_INC;
        end else if (i_load) begin
            r_mode <= i_mode;
            // All-zero is the LFSR lock-up state, so it is never used as a seed.
            if (i_mode == MODE_LFSR && i_seed == '0)
                r_value <= DATA_W'(1);
            else
                r_value <= i_seed;
        end else if (i_advance) begin
            if (r_mode == MODE_LFSR)
                r_value <= {r_value[DATA_W-2:0], w_fb};
            else
                r_value <= r_value + DATA_W'(1);
        end
    end
endmodule

// File: rtl/traffic_gen.sv
// Traffic generator: pushes a burst of payload words into the main FIFO,
// then drains the downstream channels until they stay empty.
//   state    | meaning
//   S_IDLE   | waiting for start after reset
//   S_INIT   | one-cycle init_out pulse
//   S_SETTLE | SETTLE_CYC wait cycles
//   S_RUN    | pushing words while not paused
//   S_DRAIN  | popping channels until two all-empty cycles
//   S_DONE   | run finished, waiting for start
module traffic_gen
    import traffic_gen_pkg::*;
#(
    parameter int DATA_W     = 6,
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic           clk,
    input  logic           reset,
    traffic_gen_if.master  bus
);
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYC - 1);
    localparam logic [CNT_W+3:0] POP_SAT     = {4'b0000, {CNT_W{1'b1}}};

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_len;
    logic [3:0]        r_timer;
    logic              r_empty_prev;
    logic              r_push;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_push_cnt;
    logic [CNT_W-1:0]  r_pop_cnt;

    logic              w_start_ok;
    logic              w_push;
    logic              w_all_empty;
    logic [NUM_CH-1:0] w_pop;
    logic [CNT_W+3:0]  w_pop_num;
    logic [CNT_W+3:0]  w_pop_sum;
    logic [DATA_W-1:0] w_payload;

    traffic_gen_payload #(.DATA_W(DATA_W)) u_payload (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_start_ok),
        .i_advance (w_push),
        .i_mode    (bus.mode),
        .i_seed    (bus.seed),
        .o_value   (w_payload)
    );

    assign w_start_ok  = bus.start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_all_empty = &bus.empty_in;
    // Registering on the edge that enters RUN makes push_out visible in the first RUN cycle.
    assign w_push      = (w_next == S_RUN) && !bus.pause_in && (r_push_cnt < r_len);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (bus.start) w_next = S_INIT;
            S_INIT:   w_next = S_SETTLE;
            S_SETTLE: if (r_timer == '0) w_next = (r_len == '0) ? S_DRAIN : S_RUN;
            S_RUN:    if (r_push_cnt >= r_len) w_next = S_DRAIN;
            S_DRAIN:  if (w_all_empty && r_empty_prev) w_next = S_DONE;
            S_DONE:   if (bus.start) w_next = S_INIT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop     = '0;
        w_pop_num = '0;
        if (r_state == S_RUN || r_state == S_DRAIN)
            w_pop = ~bus.empty_in;
        for (int i = 0; i < NUM_CH; i++)
            w_pop_num = w_pop_num + (CNT_W+4)'(w_pop[i]);
        w_pop_sum = {4'b0000, r_pop_cnt} + w_pop_num;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_timer      <= '0;
            r_empty_prev <= 1'b0;
            r_push       <= 1'b0;
            r_data       <= '0;
            r_push_cnt   <= '0;
            r_pop_cnt    <= '0;
        end else begin
            r_state      <= w_next;
            r_empty_prev <= w_all_empty;
            r_push       <= w_push;
            if (w_push)
                r_data <= w_payload;

            if (r_state == S_INIT)
                r_timer <= SETTLE_LOAD;
            else if (r_state == S_SETTLE && r_timer != '0)
                r_timer <= r_timer - 4'd1;

            if (w_start_ok) begin
                r_len      <= bus.burst_len;
                r_push_cnt <= '0;
                r_pop_cnt  <= '0;
            end else begin
                if (w_push && r_push_cnt != '1)
                    r_push_cnt <= r_push_cnt + CNT_W'(1);
                r_pop_cnt <= (w_pop_sum > POP_SAT) ? '1 : w_pop_sum[CNT_W-1:0];
            end
        end
    end

    assign bus.data_out = r_data;
    assign bus.push_out = r_push;
    assign bus.pop_out  = w_pop;
    assign bus.init_out = (r_state == S_INIT);
    assign bus.busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.push_cnt = r_push_cnt;
    assign bus.pop_cnt  = r_pop_cnt;
endmodule

// File: tb/tb_traffic_gen.sv
// Directed bench for traffic_gen: payload scoreboard, timing, pause,
// LFSR, drain, zero-length burst, mid-run reset and counter saturation.
module tb_traffic_gen;
    localparam int DATA_W     = 6;
    localparam int NUM_CH     = 2;
    localparam int CNT_W      = 8;
    localparam int SETTLE_CYC = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    traffic_gen_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    traffic_gen #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int                checks   = 0;
    int                failures = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] mon_exp;
    logic              pause_q = 1'b0;
    logic              track_distinct = 1'b0;
    logic              seen [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic m, input logic [DATA_W-1:0] s, input logic [CNT_W-1:0] len);
        bus.mode      = m;
        bus.seed      = s;
        bus.burst_len = len;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int n = 0;
        while (!bus.done && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.done, 1);
    endtask

    task automatic queue_inc(input logic [DATA_W-1:0] s, input int len);
        logic [DATA_W-1:0] v = s;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(v);
            v = v + DATA_W'(1);
        end
    endtask

    always @(posedge clk) pause_q <= bus.pause_in;

    // Scoreboard: every push must match the next queued payload.
    always @(negedge clk) begin
        if (!track_distinct)
            for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        if (!reset && bus.push_out) begin
            check("push_out_expected", bus.push_out, 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("data_out", bus.data_out, mon_exp);
            end
            if (track_distinct) begin
                check("lfsr_nonzero", 32'(bus.data_out != 0), 1);
                check("lfsr_distinct", seen[bus.data_out], 0);
                seen[bus.data_out] = 1'b1;
            end
        end
        if (!reset && pause_q)
            check("pause_no_push", bus.push_out, 0);
    end

    initial begin
        int                avail [NUM_CH];
        int                all_empty_run;
        logic              seen_done;
        logic [DATA_W-1:0] v;
        int                n;

        bus.start     = 1'b0;
        bus.mode      = 1'b0;
        bus.seed      = '0;
        bus.burst_len = '0;
        bus.pause_in  = 1'b0;
        bus.empty_in  = '0;
        repeat (2) @(negedge clk);

        check("rst_push_out", bus.push_out, 0);
        check("rst_init_out", bus.init_out, 0);
        check("rst_done",     bus.done, 0);
        check("rst_busy",     bus.busy, 0);
        check("rst_push_cnt", bus.push_cnt, 0);
        check("rst_pop_cnt",  bus.pop_cnt, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_pop_out",  bus.pop_out, 0);

        bus.empty_in = '1;
        reset = 1'b0;
        @(negedge clk);

        // Incrementing burst with wrap, plus an ignored start while busy.
        queue_inc(6'h2C, 18);
        pulse_start(1'b0, 6'h2C, 8'd18);
        check("a_init_out", bus.init_out, 1);
        check("a_busy", bus.busy, 1);
        @(negedge clk);
        check("a_init_one_cycle", bus.init_out, 0);
        check("a_settle1_push", bus.push_out, 0);
        @(negedge clk);
        check("a_settle2_push", bus.push_out, 0);
        @(negedge clk);
        check("a_first_push", bus.push_out, 1);
        @(negedge clk);
        bus.start = 1'b1; bus.seed = '0; bus.mode = 1'b1; bus.burst_len = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(200, "a_done");
        check("a_push_cnt", bus.push_cnt, 18);
        check("a_pop_cnt", bus.pop_cnt, 0);
        check("a_busy_done", bus.busy, 0);
        check("a_queue_drained", exp_q.size(), 0);

        // Same burst with pause_in held for four cycles.
        queue_inc(6'h2C, 18);
        pulse_start(1'b0, 6'h2C, 8'd18);
        repeat (4) @(negedge clk);
        bus.pause_in = 1'b1;
        repeat (4) @(negedge clk);
        bus.pause_in = 1'b0;
        wait_done(200, "b_done");
        check("b_push_cnt", bus.push_cnt, 18);
        check("b_queue_drained", exp_q.size(), 0);

        // LFSR x^6+x^5+1 from seed 0: full period of distinct nonzero words.
        v = 6'h01;
        for (int i = 0; i < 63; i++) begin
            exp_q.push_back(v);
            v = {v[4:0], v[5] ^ v[4]};
        end
        track_distinct = 1'b1;
        pulse_start(1'b1, 6'h00, 8'd63);
        wait_done(300, "c_done");
        track_distinct = 1'b0;
        check("c_push_cnt", bus.push_cnt, 63);
        check("c_queue_drained", exp_q.size(), 0);

        // Random empty flags with one entry per channel.
        queue_inc(6'h05, 3);
        for (int ch = 0; ch < NUM_CH; ch++) avail[ch] = 1;
        all_empty_run = 0;
        seen_done = 1'b0;
        pulse_start(1'b0, 6'h05, 8'd3);
        for (int c = 0; c < 400 && !seen_done; c++) begin
            @(negedge clk);
            if (bus.done) begin
                check("d_done_after_two_empty", 32'(all_empty_run >= 2), 1);
                seen_done = 1'b1;
            end else begin
                for (int ch = 0; ch < NUM_CH; ch++)
                    bus.empty_in[ch] = (avail[ch] == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                #1;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (bus.empty_in[ch])
                        check("d_pop_on_empty", bus.pop_out[ch], 0);
                    if (bus.pop_out[ch] && avail[ch] > 0)
                        avail[ch]--;
                end
                all_empty_run = (&bus.empty_in) ? all_empty_run + 1 : 0;
            end
        end
        check("d_done_seen", seen_done, 1);
        check("d_pop_cnt", bus.pop_cnt, NUM_CH);
        bus.empty_in = '1;

        // Zero-length burst: INIT, SETTLE x2, DRAIN, DONE with no push.
        pulse_start(1'b0, 6'h11, 8'd0);
        check("e_init_out", bus.init_out, 1);
        @(negedge clk);
        check("e_settle_busy", bus.busy, 1);
        @(negedge clk);
        check("e_settle_done", bus.done, 0);
        @(negedge clk);
        check("e_drain_busy", bus.busy, 1);
        check("e_drain_done", bus.done, 0);
        @(negedge clk);
        check("e_done", bus.done, 1);
        check("e_push_cnt", bus.push_cnt, 0);

        // Reset in the middle of RUN, then a clean restart.
        queue_inc(6'h10, 20);
        bus.empty_in = '0;
        pulse_start(1'b0, 6'h10, 8'd20);
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("f_rst_push_out", bus.push_out, 0);
        check("f_rst_pop_out",  bus.pop_out, 0);
        check("f_rst_busy",     bus.busy, 0);
        check("f_rst_init_out", bus.init_out, 0);
        check("f_rst_done",     bus.done, 0);
        check("f_rst_data_out", bus.data_out, 0);
        check("f_rst_push_cnt", bus.push_cnt, 0);
        check("f_rst_pop_cnt",  bus.pop_cnt, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        bus.empty_in = '1;
        @(negedge clk);
        queue_inc(6'h10, 5);
        pulse_start(1'b0, 6'h10, 8'd5);
        check("f_restart_init", bus.init_out, 1);
        wait_done(100, "f_done");
        check("f_push_cnt", bus.push_cnt, 5);
        check("f_queue_drained", exp_q.size(), 0);

        // Long burst with both channels always ready: pop_cnt must saturate.
        queue_inc(6'h3A, 150);
        bus.empty_in = '0;
        pulse_start(1'b0, 6'h3A, 8'd150);
        n = 0;
        while (bus.push_cnt != 8'd150 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("g_push_reached", bus.push_cnt, 150);
        bus.empty_in = '1;
        wait_done(50, "g_done");
        check("g_pop_cnt_sat", bus.pop_cnt, 255);
        check("g_push_cnt", bus.push_cnt, 150);
        check("g_queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
